hwag_cfg_seq: RTL

//  Configuration sequencer and bus owner for the hwag register file. After reset it

---
 rtl/hwag_pkg.sv | 31 +++
 rtl/hwag_cfg_seq_if.sv | 34 +++
 rtl/hwag_cfg_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hwag_pkg.sv
`default_nettype none
// ============================================================================
//  hwag_pkg
//  Shared types and constants for the hwag configuration sequencer.
//  Revision: 1.0
// ============================================================================
package hwag_pkg;

   localparam int CFG_AW = 8;
   localparam int CFG_DW = 16;

   localparam logic [CFG_AW-1:0] HWACR0_ADDR = 8'd63;
   localparam logic [CFG_AW-1:0] TERM_ADDR   = 8'hFF;

   typedef enum logic [2:0] {
      CS_FETCH  = 3'd0,
      CS_WAIT   = 3'd1,
      CS_WRITE  = 3'd2,
      CS_VREQ   = 3'd3,
      CS_VCHK   = 3'd4,
      CS_ENABLE = 3'd5,
      CS_RUN    = 3'd6
   } cfg_state_t;

   typedef struct packed {
      logic [CFG_AW-1:0] addr;
      logic [CFG_DW-1:0] data;
   } cfg_entry_t;

endpackage
`default_nettype wire

// File: rtl/hwag_cfg_seq_if.sv
`default_nettype none
// ============================================================================
//  hwag_cfg_seq_if
//  Host request port and register bus owned by the configuration sequencer.
//  Revision: 1.0
// ============================================================================
interface hwag_cfg_seq_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_ack;
   logic [DW-1:0] host_rdata;

   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata;
   logic          reg_we;
   logic          reg_re;
   logic [DW-1:0] reg_rdata;

   modport master (
      input  host_req, host_we, host_addr, host_wdata, reg_rdata,
      output host_ack, host_rdata, reg_addr, reg_wdata, reg_we, reg_re
   );

   modport slave (
      output host_req, host_we, host_addr, host_wdata, reg_rdata,
      input  host_ack, host_rdata, reg_addr, reg_wdata, reg_we, reg_re
   );
endinterface
`default_nettype wire

// File: rtl/hwag_cfg_seq.sv
`default_nettype none
// ============================================================================
//  hwag_cfg_seq
//  Boot-table loader with read-back verify, then host arbiter for the reg bus.
//  Revision: 1.0
// ============================================================================
module hwag_cfg_seq #(
   parameter int            AW        = 8,
   parameter int            DW        = 16,
   parameter int            TW        = 5,
   parameter logic [AW-1:0] TERM_ADDR = AW'(hwag_pkg::TERM_ADDR)
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   output logic [TW-1:0]      rom_idx,
   input  wire logic [AW+DW-1:0] rom_entry,
   output logic               boot_done,
   output logic               boot_err,
   output logic [AW-1:0]      err_addr,
   output logic               hwag_ena,
   hwag_cfg_seq_if.master     bus
);

   localparam logic [2:0] S_FETCH  = hwag_pkg::CS_FETCH;
   localparam logic [2:0] S_WAIT   = hwag_pkg::CS_WAIT;
   localparam logic [2:0] S_WRITE  = hwag_pkg::CS_WRITE;
   localparam logic [2:0] S_VREQ   = hwag_pkg::CS_VREQ;
   localparam logic [2:0] S_VCHK   = hwag_pkg::CS_VCHK;
   localparam logic [2:0] S_ENABLE = hwag_pkg::CS_ENABLE;
   localparam logic [2:0] S_RUN    = hwag_pkg::CS_RUN;

   localparam logic [TW-1:0] C_IDX_LAST = '1;
   localparam logic [AW-1:0] C_HWACR0   = AW'(hwag_pkg::HWACR0_ADDR);

   logic [2:0]    r_state;
   logic [TW-1:0] r_idx;
   logic [AW-1:0] r_ent_addr;
   logic [DW-1:0] r_ent_data;
   logic          r_boot_done;
   logic          r_boot_err;
   logic [AW-1:0] r_err_addr;
   logic          r_ena;
   logic          r_ack;
   logic          r_ack_rd;

   logic          w_host_go;
   logic          w_term;
   logic          w_match;
   logic [AW-1:0] w_reg_addr;
   logic [DW-1:0] w_reg_wdata;
   logic          w_reg_we;
   logic          w_reg_re;

   // The ack cycle itself blocks acceptance, so a held request is never served twice.
   assign w_host_go = (r_state == S_RUN) && bus.host_req && !r_ack;

   // The last index is never fetched as data: reaching it ends the table.
   assign w_term  = (rom_entry[AW+DW-1:DW] == TERM_ADDR) || (r_idx == C_IDX_LAST);
   assign w_match = (bus.reg_rdata == r_ent_data);

   always_comb begin
      w_reg_addr  = '0;
      w_reg_wdata = '0;
      w_reg_we    = 1'b0;
      w_reg_re    = 1'b0;
      case (r_state)
         S_WRITE: begin
            w_reg_addr  = r_ent_addr;
            w_reg_wdata = r_ent_data;
            w_reg_we    = 1'b1;
         end
         S_VREQ: begin
            w_reg_addr = r_ent_addr;
            w_reg_re   = 1'b1;
         end
         S_RUN: begin
            if (w_host_go) begin
               w_reg_addr = bus.host_addr;
               if (bus.host_we) begin
                  w_reg_wdata = bus.host_wdata;
                  w_reg_we    = 1'b1;
               end else begin
                  w_reg_re = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_idx       <= '0;
         r_ent_addr  <= '0;
         r_ent_data  <= '0;
         r_boot_done <= 1'b0;
         r_boot_err  <= 1'b0;
         r_err_addr  <= '0;
         r_ena       <= 1'b0;
         r_ack       <= 1'b0;
         r_ack_rd    <= 1'b0;
      end else begin
         r_ack    <= 1'b0;
         r_ack_rd <= 1'b0;
         case (r_state)
            S_FETCH: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_ent_addr <= rom_entry[AW+DW-1:DW];
               r_ent_data <= rom_entry[DW-1:0];
               if (w_term) begin
                  r_state     <= S_ENABLE;
                  r_boot_done <= 1'b1;
                  r_ena       <= 1'b1;
               end else begin
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_state <= S_VREQ;
            end
            S_VREQ: begin
               r_state <= S_VCHK;
            end
            S_VCHK: begin
               if (w_match) begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_FETCH;
               end else begin
                  r_boot_err <= 1'b1;
                  r_err_addr <= r_ent_addr;
                  r_state    <= S_RUN;
               end
            end
            S_ENABLE: begin
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_host_go) begin
                  r_ack    <= 1'b1;
                  r_ack_rd <= !bus.host_we;
                  // A failed boot leaves the engine locked off regardless of host writes.
                  if (bus.host_we && (bus.host_addr == C_HWACR0)) begin
                     r_ena <= bus.host_wdata[0] && !r_boot_err;
                  end
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign rom_idx        = r_idx;
   assign boot_done      = r_boot_done;
   assign boot_err       = r_boot_err;
   assign err_addr       = r_err_addr;
   assign hwag_ena       = r_ena;

   assign bus.reg_addr   = w_reg_addr;
   assign bus.reg_wdata  = w_reg_wdata;
   assign bus.reg_we     = w_reg_we;
   assign bus.reg_re     = w_reg_re;
   assign bus.host_ack   = r_ack;
   assign bus.host_rdata = r_ack_rd ? bus.reg_rdata : '0;

endmodule
`default_nettype wire
